// File: rtl/uart_host_ctrl_if.sv
// Register port between the host controller and the UART register block.
interface uart_host_ctrl_if;
    logic [2:0] uart_addr_o;
    logic [7:0] uart_dat_o;
    logic [7:0] uart_dat_i;
    logic       uart_we_o;
    logic       uart_re_o;

    modport master (
        output uart_addr_o, uart_dat_o, uart_we_o, uart_re_o,
        input  uart_dat_i
    );

    modport slave (
        input  uart_addr_o, uart_dat_o, uart_we_o, uart_re_o,
        output uart_dat_i
    );
endinterface

// File: rtl/uart_host_ctrl.sv
// Polled-mode UART host controller: programs the UART after reset or on
// request, then moves bytes between the TX/RX streams and the UART FIFOs
// by polling LSR. Every register access is a registered one-cycle strobe;
// the phase bit makes the following cycle idle.
module uart_host_ctrl #(
    parameter logic [15:0] DL_INIT  = 16'd27,
    parameter logic [7:0]  LCR_INIT = 8'h03,
    parameter logic [1:0]  FCR_TRIG = 2'b11,
    parameter int unsigned POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        wb_rst_ni,
    input  logic        cfg_req_i,
    input  logic [15:0] cfg_dl_i,
    input  logic [7:0]  cfg_lcr_i,
    output logic        init_done_o,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    input  logic        rx_ready_i,
    output logic [3:0]  rx_err_o,
    uart_host_ctrl_if.master uart
);

    typedef enum logic [3:0] {
        INIT_LCRD, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, INIT_IER,
        IDLE, POLL, RX_RD, TX_WR
    } state_e;

    typedef enum logic [1:0] {ACT_NONE, ACT_RX, ACT_TX} act_e;

    localparam logic [3:0] GAP_LAST = 4'(POLL_GAP - 1);

    state_e      state_q, state_d;
    logic        ph_q, ph_d;
    logic [3:0]  gap_q, gap_d;
    act_e        act_q, act_d;
    logic        rr_q, rr_d;          // 0: RX wins a tie, 1: TX wins
    logic [15:0] dl_q, dl_d;
    logic [6:0]  lcr_q, lcr_d;
    logic        pend_q, pend_d;
    logic [15:0] pdl_q, pdl_d;
    logic [6:0]  plcr_q, plcr_d;
    logic        init_done_q, init_done_d;
    logic        tx_full_q, tx_full_d;
    logic [7:0]  tx_buf_q, tx_buf_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_buf_q, rx_buf_d;
    logic [3:0]  rx_err_q, rx_err_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        we_q, we_d;
    logic        re_q, re_d;

    // LCR bit 7 is the DLAB bit, which the init sequence drives itself.
    logic unused_lcr7;
    assign unused_lcr7 = cfg_lcr_i[7];

    logic [15:0] dl_wr;
    assign dl_wr = (dl_q == 16'd0) ? 16'd1 : dl_q;

    logic        is_acc;
    logic        acc_we;
    logic [2:0]  acc_addr;
    logic [7:0]  acc_dat;
    state_e      acc_next;
    logic        rx_cand, tx_cand;

    // Decode the register access owned by the current state.
    always_comb begin
        is_acc   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = 3'd0;
        acc_dat  = 8'h00;
        acc_next = IDLE;
        case (state_q)
            INIT_LCRD: begin acc_addr = 3'd3; acc_dat = {1'b1, lcr_q}; acc_next = INIT_DLL; end
            INIT_DLL:  begin acc_addr = 3'd0; acc_dat = dl_wr[7:0];    acc_next = INIT_DLM; end
            INIT_DLM:  begin acc_addr = 3'd1; acc_dat = dl_wr[15:8];   acc_next = INIT_LCR; end
            INIT_LCR:  begin acc_addr = 3'd3; acc_dat = {1'b0, lcr_q}; acc_next = INIT_FCR; end
            INIT_FCR:  begin acc_addr = 3'd2; acc_dat = {FCR_TRIG, 3'b000, 3'b110}; acc_next = INIT_IER; end
            INIT_IER:  begin acc_addr = 3'd1; acc_dat = 8'h00; end
            POLL:      begin acc_we = 1'b0; acc_addr = 3'd5; end
            RX_RD:     begin acc_we = 1'b0; acc_addr = 3'd0; end
            TX_WR:     begin acc_addr = 3'd0; acc_dat = tx_buf_q; end
            default:   is_acc = 1'b0;
        endcase
    end

    // Next-state, buffer and bus-output logic.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        gap_d       = gap_q;
        act_d       = act_q;
        rr_d        = rr_q;
        dl_d        = dl_q;
        lcr_d       = lcr_q;
        pend_d      = pend_q;
        pdl_d       = pdl_q;
        plcr_d      = plcr_q;
        init_done_d = init_done_q;
        tx_full_d   = tx_full_q;
        tx_buf_d    = tx_buf_q;
        rx_valid_d  = rx_valid_q;
        rx_buf_d    = rx_buf_q;
        rx_err_d    = 4'd0;
        addr_d      = addr_q;
        dout_d      = dout_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        rx_cand     = uart.uart_dat_i[0] & ~rx_valid_q;
        tx_cand     = uart.uart_dat_i[5] & tx_full_q;

        if (tx_valid_i && tx_ready_o) begin
            tx_full_d = 1'b1;
            tx_buf_d  = tx_data_i;
        end
        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
        if (cfg_req_i) begin
            pend_d = 1'b1;
            pdl_d  = cfg_dl_i;
            plcr_d = cfg_lcr_i[6:0];
        end
        if (state_q == IDLE) init_done_d = 1'b1;

        if (is_acc && !ph_q) begin
            // Launch the strobe; it is visible for exactly the next cycle.
            we_d   = acc_we;
            re_d   = ~acc_we;
            addr_d = acc_addr;
            dout_d = acc_dat;
            ph_d   = 1'b1;
        end else if (is_acc) begin
            // Strobe cycle: read data is valid now, drop the strobe.
            ph_d    = 1'b0;
            state_d = acc_next;
            gap_d   = 4'd0;
            case (state_q)
                POLL: begin
                    rx_err_d = uart.uart_dat_i[4:1];
                    if (rx_cand && tx_cand) act_d = rr_q ? ACT_TX : ACT_RX;
                    else if (rx_cand)       act_d = ACT_RX;
                    else if (tx_cand)       act_d = ACT_TX;
                    else                    act_d = ACT_NONE;
                end
                RX_RD: begin
                    rx_buf_d   = uart.uart_dat_i;
                    rx_valid_d = 1'b1;
                    rr_d       = ~rr_q;
                    act_d      = ACT_NONE;
                end
                TX_WR: begin
                    tx_full_d = 1'b0;
                    rr_d      = ~rr_q;
                    act_d     = ACT_NONE;
                end
                default: ;
            endcase
        end else if (gap_q != GAP_LAST) begin
            gap_d = gap_q + 4'd1;
        end else if (pend_q) begin
            // Reconfiguration wins over any chosen action; init resets the FIFOs.
            state_d = INIT_LCRD;
            dl_d    = pdl_q;
            lcr_d   = plcr_q;
            pend_d  = cfg_req_i;
            act_d   = ACT_NONE;
        end else if (act_q == ACT_RX) begin
            state_d = RX_RD;
        end else if (act_q == ACT_TX) begin
            state_d = TX_WR;
        end else if (tx_full_q || !rx_valid_q) begin
            state_d = POLL;
        end

        if (state_d == INIT_LCRD && state_q != INIT_LCRD) init_done_d = 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= INIT_LCRD;
            ph_q        <= 1'b0;
            gap_q       <= 4'd0;
            act_q       <= ACT_NONE;
            rr_q        <= 1'b0;
            dl_q        <= DL_INIT;
            lcr_q       <= LCR_INIT[6:0];
            pend_q      <= 1'b0;
            pdl_q       <= 16'd0;
            plcr_q      <= 7'd0;
            init_done_q <= 1'b0;
            tx_full_q   <= 1'b0;
            tx_buf_q    <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_buf_q    <= 8'h00;
            rx_err_q    <= 4'd0;
            addr_q      <= 3'd0;
            dout_q      <= 8'h00;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            gap_q       <= gap_d;
            act_q       <= act_d;
            rr_q        <= rr_d;
            dl_q        <= dl_d;
            lcr_q       <= lcr_d;
            pend_q      <= pend_d;
            pdl_q       <= pdl_d;
            plcr_q      <= plcr_d;
            init_done_q <= init_done_d;
            tx_full_q   <= tx_full_d;
            tx_buf_q    <= tx_buf_d;
            rx_valid_q  <= rx_valid_d;
            rx_buf_q    <= rx_buf_d;
            rx_err_q    <= rx_err_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            we_q        <= we_d;
            re_q        <= re_d;
        end
    end

    assign init_done_o      = init_done_q;
    assign tx_ready_o       = ~tx_full_q & init_done_q;
    assign rx_valid_o       = rx_valid_q;
    assign rx_data_o        = rx_buf_q;
    assign rx_err_o         = rx_err_q;
    assign uart.uart_addr_o = addr_q;
    assign uart.uart_dat_o  = dout_q;
    assign uart.uart_we_o   = we_q;
    assign uart.uart_re_o   = re_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed bench for uart_host_ctrl with a scoreboard: expected bus writes,
// RX bytes and error pulses are queued by the stimulus and consumed by a
// negedge monitor.
module tb_uart_host_ctrl;
    logic        clk = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        cfg_req_i = 1'b0;
    logic [15:0] cfg_dl_i = 16'd0;
    logic [7:0]  cfg_lcr_i = 8'h00;
    logic        init_done_o;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_data_i = 8'h00;
    logic        tx_ready_o;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        rx_ready_i = 1'b0;
    logic [3:0]  rx_err_o;
    logic [7:0]  lsr = 8'h00;
    logic [7:0]  rb = 8'h00;

    int errors = 0;
    int checks = 0;

    logic [10:0] exp_wr[$];
    logic [7:0]  exp_rx[$];
    logic [3:0]  exp_err[$];

    uart_host_ctrl_if u_if ();

    // UART register block model: read data is combinational from the address.
    assign u_if.uart_dat_i = (u_if.uart_addr_o == 3'd5) ? lsr :
                             (u_if.uart_addr_o == 3'd0) ? rb  : 8'h00;

    uart_host_ctrl dut (
        .clk         (clk),
        .wb_rst_ni   (wb_rst_ni),
        .cfg_req_i   (cfg_req_i),
        .cfg_dl_i    (cfg_dl_i),
        .cfg_lcr_i   (cfg_lcr_i),
        .init_done_o (init_done_o),
        .tx_valid_i  (tx_valid_i),
        .tx_data_i   (tx_data_i),
        .tx_ready_o  (tx_ready_o),
        .rx_valid_o  (rx_valid_o),
        .rx_data_o   (rx_data_o),
        .rx_ready_i  (rx_ready_i),
        .rx_err_o    (rx_err_o),
        .uart        (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic push_init(input logic [7:0] lcr, input logic [15:0] dl);
        push_wr(3'd3, {1'b1, lcr[6:0]});
        push_wr(3'd0, dl[7:0]);
        push_wr(3'd1, dl[15:8]);
        push_wr(3'd3, {1'b0, lcr[6:0]});
        push_wr(3'd2, 8'hC6);
        push_wr(3'd1, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tx(input logic [7:0] d);
        logic acc;
        logic rdy;
        acc = 1'b0;
        tx_valid_i = 1'b1;
        tx_data_i  = d;
        for (int i = 0; i < 300 && !acc; i++) begin
            rdy = tx_ready_o;
            tick();
            acc = rdy;
        end
        tx_valid_i = 1'b0;
        chk("tx_accept", {31'd0, acc}, 32'd1);
    endtask

    // Monitor: bus legality plus scoreboard pops on every DUT output event.
    logic prev_stb = 1'b0;
    initial forever begin
        @(negedge clk);
        if (u_if.uart_we_o || u_if.uart_re_o) begin
            chk("bus_excl", {31'd0, u_if.uart_we_o & u_if.uart_re_o}, 32'd0);
            chk("bus_gap", {31'd0, prev_stb}, 32'd0);
        end
        if (u_if.uart_we_o) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: got %0h:%0h expected none", u_if.uart_addr_o, u_if.uart_dat_o);
            end else chk("wr", {21'd0, u_if.uart_addr_o, u_if.uart_dat_o}, {21'd0, exp_wr.pop_front()});
        end
        if (rx_valid_o && rx_ready_i) begin
            if (exp_rx.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data_o);
            end else chk("rx_data", {24'd0, rx_data_o}, {24'd0, exp_rx.pop_front()});
        end
        if (rx_err_o != 4'd0) begin
            if (exp_err.size() == 0) begin
                checks++; errors++;
                $display("FAIL err_unexpected: got %0h expected none", rx_err_o);
            end else chk("rx_err", {28'd0, rx_err_o}, {28'd0, exp_err.pop_front()});
        end
        prev_stb = u_if.uart_we_o | u_if.uart_re_o;
    end

    initial begin
        logic found;
        int   cnt;

        // Reset values
        repeat (3) tick();
        chk("rst_we", {31'd0, u_if.uart_we_o}, 32'd0);
        chk("rst_re", {31'd0, u_if.uart_re_o}, 32'd0);
        chk("rst_addr", {29'd0, u_if.uart_addr_o}, 32'd0);
        chk("rst_dat", {24'd0, u_if.uart_dat_o}, 32'd0);
        chk("rst_done", {31'd0, init_done_o}, 32'd0);
        chk("rst_txrdy", {31'd0, tx_ready_o}, 32'd0);
        chk("rst_rxv", {31'd0, rx_valid_o}, 32'd0);
        chk("rst_err", {28'd0, rx_err_o}, 32'd0);

        // Default init sequence: one write every other cycle, done at cycle 13
        push_init(8'h03, 16'd27);
        wb_rst_ni = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            chk($sformatf("init_we_c%0d", c), {31'd0, u_if.uart_we_o},
                {31'd0, (c % 2 == 1) && (c <= 11)});
            if (c >= 12) chk($sformatf("init_done_c%0d", c), {31'd0, init_done_o}, {31'd0, c == 13});
        end

        // TX: A5 written after a poll sees THRE
        lsr = 8'h60;
        push_wr(3'd0, 8'hA5);
        send_tx(8'hA5);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = u_if.uart_we_o && (u_if.uart_addr_o == 3'd0);
        end
        chk("tx_wr_seen", {31'd0, found}, 32'd1);
        chk("tx_rdy_during_wr", {31'd0, tx_ready_o}, 32'd0);
        tick();
        chk("tx_rdy_after_wr", {31'd0, tx_ready_o}, 32'd1);

        // RX with back-pressure: 3C held, no further RB reads
        rb = 8'h3C;
        rx_ready_i = 1'b0;
        exp_rx.push_back(8'h3C);
        lsr = 8'h61;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = rx_valid_o;
        end
        chk("rx_valid_seen", {31'd0, found}, 32'd1);
        chk("rx_data_first", {24'd0, rx_data_o}, 32'h3C);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (u_if.uart_re_o && u_if.uart_addr_o == 3'd0) cnt++;
        end
        chk("rx_no_reread", cnt, 0);
        chk("rx_valid_held", {31'd0, rx_valid_o}, 32'd1);
        chk("rx_data_held", {24'd0, rx_data_o}, 32'h3C);
        lsr = 8'h60;
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        chk("rx_drained", {31'd0, rx_valid_o}, 32'd0);

        // Round robin: both candidates, RX first then TX
        lsr = 8'h00;
        rx_ready_i = 1'b1;
        rb = 8'hC3;
        exp_rx.push_back(8'hC3);
        push_wr(3'd0, 8'h5A);
        send_tx(8'h5A);
        lsr = 8'h61;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (u_if.uart_re_o && u_if.uart_addr_o == 3'd0) cnt++;
            found = u_if.uart_we_o && (u_if.uart_addr_o == 3'd0);
        end
        lsr = 8'h60;
        chk("rr_tx_seen", {31'd0, found}, 32'd1);
        chk("rr_rx_before_tx", cnt, 1);
        repeat (5) tick();

        // Line errors: LSR=9B -> pulse 1101, then RX_RD
        rb = 8'h77;
        exp_rx.push_back(8'h77);
        exp_err.push_back(4'b1101);
        lsr = 8'h9B;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = (rx_err_o != 4'd0);
        end
        lsr = 8'h60;
        chk("err_seen", {31'd0, found}, 32'd1);
        tick();
        chk("err_one_cycle", {28'd0, rx_err_o}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = u_if.uart_re_o && (u_if.uart_addr_o == 3'd0);
        end
        chk("err_rx_rd", {31'd0, found}, 32'd1);
        repeat (5) tick();
        rx_ready_i = 1'b0;

        // Reconfiguration requested during TX_WR, divisor 0 becomes 1
        lsr = 8'h00;
        push_wr(3'd0, 8'h11);
        send_tx(8'h11);
        lsr = 8'h60;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = u_if.uart_we_o && (u_if.uart_addr_o == 3'd0);
        end
        chk("cfg_tx_wr_seen", {31'd0, found}, 32'd1);
        cfg_req_i = 1'b1;
        cfg_dl_i  = 16'd0;
        cfg_lcr_i = 8'h9F;
        push_init(8'h9F, 16'd1);
        tick();
        cfg_req_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = !init_done_o;
        end
        chk("cfg_done_fell", {31'd0, found}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = init_done_o;
        end
        chk("cfg_done_rose", {31'd0, found}, 32'd1);

        // Asynchronous reset mid-access drops the strobe and loses the TX byte
        lsr = 8'h00;
        send_tx(8'h22);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = u_if.uart_re_o;
        end
        chk("mid_poll_seen", {31'd0, found}, 32'd1);
        #2 wb_rst_ni = 1'b0;
        #1;
        chk("arst_re", {31'd0, u_if.uart_re_o}, 32'd0);
        chk("arst_txrdy", {31'd0, tx_ready_o}, 32'd0);
        chk("arst_done", {31'd0, init_done_o}, 32'd0);
        repeat (2) tick();
        push_init(8'h03, 16'd27);
        wb_rst_ni = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = init_done_o;
        end
        chk("arst_reinit", {31'd0, found}, 32'd1);
        chk("arst_tx_empty", {31'd0, tx_ready_o}, 32'd1);
        lsr = 8'h60;
        repeat (60) tick();

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rx_queue_empty", exp_rx.size(), 0);
        chk("err_queue_empty", exp_err.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
